undo_buffer: RTL and testbench
==============================

// Module: undo_buffer
// PURPOSE
//  Undo-stack stage for the AXA pipeline: sits beside the ALU stage and register-read stage.
//  The ALU stage pushes a destination's pre-write value for lhi/llo/shr/or/and/dup.
//  The register-read stage pops the most recent value for SRC_UNDO operands.
//  LIFO ring of DEPTH words: overflow overwrites the oldest entry; same-cycle push+pop is bypassed.
// PARAMETERS
//  WIDTH   16  data word width (matches WORD)
//  DEPTH   16  stack entries; power of two, >= 2
//  CW      5   count width = log2(DEPTH)+1
// PORTS
//  clk         in   1      rising-edge clock, single domain
//  reset       in   1      asynchronous, active-low reset
//  clr         in   1      synchronous flush of all entries
//  push_valid  in   1      ALU stage pushes push_data this cycle
//  push_data   in   WIDTH  dest value before overwrite
//  pop_req     in   1      register-read stage requests top entry
//  pop_valid   out  1      pop_data valid (1 cycle after pop_req)
//  pop_data    out  WIDTH  popped word
//  underflow   out  1      1-cycle pulse: pop on empty with no push
//  dropped     out  1      sticky: an entry was overwritten on a full push
//  count       out  CW     live entries, 0..DEPTH
//  empty       out  1      count==0 (combinational from count reg)
//  full        out  1      count==DEPTH (combinational from count reg)
// BEHAVIOUR
//  - Reset (reset==0, async): tp=0, count=0, pop_valid=0, pop_data=0, underflow=0, dropped=0.
//    Storage contents are undefined; nothing is read before it is written.
//  - State: tp = index of next free slot (mod DEPTH); top entry = mem[tp-1 mod DEPTH].
//  - All outputs are registered.
//  - Pop latency is exactly 1 cycle: pop_req at edge N gives pop_valid and pop_data at edge N+1.
//  - pop_valid deasserts when no pop occurs. pop_data holds its last value.
//  - Per-cycle priority: clr > (push & pop) > push > pop.
//    clr:   tp=0, count=0, dropped=0, pop_valid=0, underflow=0; push and pop are ignored.
//    push & pop: pop_data=push_data, pop_valid=1; mem, tp and count are unchanged (bypass).
//    push, not full: mem[tp]=push_data, tp++, count++.
//    push, full: mem[tp]=push_data (oldest lost), tp++, count stays DEPTH, dropped=1.
//    pop, count>0: pop_data=mem[tp-1], tp--, count--, pop_valid=1.
//    pop, count==0: pop_data=0, pop_valid=1, underflow=1 for one cycle; tp and count unchanged.
//  - tp increments and decrements wrap modulo DEPTH. count saturates at DEPTH and never goes below 0.
//  - A push in cycle N is visible to a pop in cycle N+1; no read-during-write hazard inside the block.
//  - Reset asserted mid-operation aborts any pending pop: pop_valid is 0 on release.
//  - First edge after reset release behaves as a normal cycle.
// STRUCTURE
//  - Shared package axa_pkg holds:
//    WORD width, UNDO_DEPTH, SRC_UNDO=2'b11, and the push-qualifying opcode list.
//    The ALU stage and this block decode push_valid from the same list.
//  - One sub-module, undo_ram: DEPTH x WIDTH, 1 synchronous write port, 1 combinational read port.
//  - Pointer/count/flag logic and output registers live in undo_buffer itself.
// TESTING
//  1. Reset; push 0x1111, 0x2222, 0x3333; pop x3 -> pop_data 3333, 2222, 1111.
//     Each pop_valid 1 cycle after its pop_req; count ends 0; empty=1.
//  2. Pop on empty -> pop_valid=1, pop_data=0, underflow high exactly 1 cycle; count stays 0.
//  3. Push 17 values 0x0000..0x0010 (DEPTH=16) -> count=16, full=1, dropped=1.
//     16 pops return 0x0010 down to 0x0001; 17th pop underflows.
//  4. With 0xAAAA on top: push 0x5555 and pop in the same cycle -> pop_data=0x5555, count unchanged.
//     Next pop returns 0xAAAA.
//  5. Push 0xBEEF; assert clr together with pop_req -> pop_valid=0, count=0, dropped=0.
//     Next pop underflows.
//  6. Push 2 values, assert reset low mid-cycle with pop_req -> outputs 0 immediately.
//     After release, count=0 and the next pop underflows.

Source files
------------

// File: rtl/axa_pkg.sv
// Shared AXA definitions: word width, undo depth, operand selects
// and the opcode list whose destinations are saved on the undo stack.
package axa_pkg;

  localparam int WORD       = 16;
  localparam int UNDO_DEPTH = 16;

  localparam logic [1:0] SRC_UNDO = 2'b11;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LHI = 4'h1,
    OP_LLO = 4'h2,
    OP_SHR = 4'h3,
    OP_OR  = 4'h4,
    OP_AND = 4'h5,
    OP_DUP = 4'h6,
    OP_ADD = 4'h7,
    OP_SUB = 4'h8,
    OP_JMP = 4'h9
  } op_e;

  // The ALU stage and the undo stack both decode pushes from this list.
  function automatic logic undo_push_op(input op_e op);
    return op inside {OP_LHI, OP_LLO, OP_SHR,
                      OP_OR, OP_AND, OP_DUP};
  endfunction

endpackage

// File: rtl/undo_ram.sv
// Undo storage: DEPTH x WIDTH, one synchronous write port and one
// combinational read port. Ports: clk, i_we/i_waddr/i_wdata, i_raddr, o_rdata.
module undo_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/undo_buffer.sv
// LIFO undo ring beside the ALU and register-read stages.
// Ports: clk, reset(async low), clr, push_valid/push_data, pop_req,
// pop_valid/pop_data, underflow, dropped(sticky), count, empty, full.
module undo_buffer
  import axa_pkg::*;
#(
  parameter int WIDTH = WORD,
  parameter int DEPTH = UNDO_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_req,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  output logic             underflow,
  output logic             dropped,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    r_tp;
  logic [CW-1:0]    r_count;
  logic             r_pop_valid;
  logic [WIDTH-1:0] r_pop_data;
  logic             r_underflow;
  logic             r_dropped;

  logic [AW-1:0]    w_top;
  logic [WIDTH-1:0] w_rdata;
  logic             w_we;
  logic             w_full;
  logic             w_empty;

  assign w_top   = r_tp - AW'(1);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Same-cycle push+pop is a bypass, so only a lone push writes.
  assign w_we = !clr && push_valid && !pop_req;

  undo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_tp),
    .i_wdata (push_data),
    .i_raddr (w_top),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tp        <= '0;
      r_count     <= '0;
      r_pop_valid <= 1'b0;
      r_pop_data  <= '0;
      r_underflow <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      r_pop_valid <= 1'b0;
      r_underflow <= 1'b0;
      if (clr) begin
        r_tp      <= '0;
        r_count   <= '0;
        r_dropped <= 1'b0;
      end else if (push_valid && pop_req) begin
        r_pop_data  <= push_data;
        r_pop_valid <= 1'b1;
      end else if (push_valid) begin
        // A full push overwrites the oldest slot, which is mem[tp].
        r_tp <= r_tp + AW'(1);
        if (w_full) r_dropped <= 1'b1;
        else        r_count   <= r_count + CW'(1);
      end else if (pop_req) begin
        r_pop_valid <= 1'b1;
        if (w_empty) begin
          r_pop_data  <= '0;
          r_underflow <= 1'b1;
        end else begin
          r_pop_data <= w_rdata;
          r_tp       <= w_top;
          r_count    <= r_count - CW'(1);
        end
      end
    end
  end

  assign pop_valid = r_pop_valid;
  assign pop_data  = r_pop_data;
  assign underflow = r_underflow;
  assign dropped   = r_dropped;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;

endmodule

// File: tb/tb_undo_buffer.sv
// Bench for undo_buffer: directed scenarios then random traffic,
// all checked against a queue-based stack model.
module tb_undo_buffer;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int CW = 5;

  logic          clk;
  logic          reset;
  logic          clr;
  logic          push_valid;
  logic [W-1:0]  push_data;
  logic          pop_req;
  logic          pop_valid;
  logic [W-1:0]  pop_data;
  logic          underflow;
  logic          dropped;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  undo_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .push_valid (push_valid),
    .push_data  (push_data),
    .pop_req    (pop_req),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .underflow  (underflow),
    .dropped    (dropped),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: a plain queue, oldest at the front, top at the back.
  logic [W-1:0] m_q [$];
  logic         m_pv;
  logic [W-1:0] m_pd;
  logic         m_uf;
  logic         m_drop;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pv"}, pop_valid, m_pv);
    chk({tag, ".pd"}, pop_data, m_pd);
    chk({tag, ".uf"}, underflow, m_uf);
    chk({tag, ".drop"}, dropped, m_drop);
    chk({tag, ".cnt"}, count, m_q.size());
    chk({tag, ".empty"}, empty, m_q.size() == 0);
    chk({tag, ".full"}, full, m_q.size() == D);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pv   = 1'b0;
    m_pd   = '0;
    m_uf   = 1'b0;
    m_drop = 1'b0;
  endtask

  task automatic cyc(input string tag, input logic c, input logic p,
                     input logic [W-1:0] d, input logic r);
    clr        = c;
    push_valid = p;
    push_data  = d;
    pop_req    = r;
    @(posedge clk);
    #1;
    m_pv = 1'b0;
    m_uf = 1'b0;
    if (c) begin
      m_q.delete();
      m_drop = 1'b0;
    end else if (p && r) begin
      m_pd = d;
      m_pv = 1'b1;
    end else if (p) begin
      if (m_q.size() == D) begin
        void'(m_q.pop_front());
        m_drop = 1'b1;
      end
      m_q.push_back(d);
    end else if (r) begin
      m_pv = 1'b1;
      if (m_q.size() > 0) begin
        m_pd = m_q.pop_back();
      end else begin
        m_pd = '0;
        m_uf = 1'b1;
      end
    end
    chk_all(tag);
    clr        = 1'b0;
    push_valid = 1'b0;
    pop_req    = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] d);
    cyc("push", 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic pop(input string tag);
    cyc(tag, 1'b0, 1'b0, '0, 1'b1);
  endtask

  // Reset lands between edges with a pop pending.
  task automatic mid_reset();
    pop_req = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk_all("rst_async");
    @(posedge clk);
    #1;
    pop_req = 1'b0;
    reset   = 1'b1;
    chk_all("rst_hold");
  endtask

  initial begin
    reset      = 1'b0;
    clr        = 1'b0;
    push_valid = 1'b0;
    push_data  = '0;
    pop_req    = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk_all("reset");
    reset = 1'b1;

    // 1: simple LIFO order
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    pop("t1a");
    chk("t1a.lit", pop_data, 16'h3333);
    pop("t1b");
    chk("t1b.lit", pop_data, 16'h2222);
    pop("t1c");
    chk("t1c.lit", pop_data, 16'h1111);
    chk("t1.empty", empty, 1'b1);
    cyc("t1.idle", 1'b0, 1'b0, '0, 1'b0);

    // 2: pop on empty
    pop("t2");
    chk("t2.uf.lit", underflow, 1'b1);
    cyc("t2.after", 1'b0, 1'b0, '0, 1'b0);
    chk("t2.uf.gone", underflow, 1'b0);

    // 3: overflow drops the oldest
    for (int i = 0; i <= 16; i++) push(W'(i));
    chk("t3.full", full, 1'b1);
    chk("t3.drop", dropped, 1'b1);
    for (int i = 16; i >= 1; i--) begin
      pop("t3.pop");
      chk("t3.lit", pop_data, W'(i));
    end
    pop("t3.under");
    chk("t3.uf.lit", underflow, 1'b1);

    // 4: bypass
    push(16'hAAAA);
    cyc("t4.byp", 1'b0, 1'b1, 16'h5555, 1'b1);
    chk("t4.byp.lit", pop_data, 16'h5555);
    pop("t4.next");
    chk("t4.next.lit", pop_data, 16'hAAAA);

    // 5: clr beats pop
    push(16'hBEEF);
    cyc("t5.clr", 1'b1, 1'b0, '0, 1'b1);
    chk("t5.dropclr", dropped, 1'b0);
    pop("t5.under");

    // 6: async reset mid-operation
    push(16'h0123);
    push(16'h4567);
    mid_reset();
    pop("t6.under");

    // Random traffic, weighted towards push so the ring fills and wraps.
    for (int n = 0; n < 3000; n++) begin
      int k;
      k = $urandom_range(99);
      if (n == 1500) begin
        mid_reset();
      end else begin
        cyc("rnd",
            k < 2,
            ($urandom_range(99) < 55),
            W'($urandom),
            ($urandom_range(99) < 40));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
